// File: rtl/mac_pkg.sv
// Shared types and defaults for the multiply-accumulate path.
// Holds the accumulator FSM states and width helpers.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 7;
  localparam int DEF_ACC_W  = 10;

  // Smallest accumulator width that cannot carry out over a full frame.
  function automatic int sum_w(input int prod_w, input int count);
    int w;
    w = prod_w;
    while ((1 << (w - prod_w)) < count) w++;
    return w;
  endfunction

endpackage

// File: rtl/prod_accum.sv
// Frame accumulator after the partial-product multiplier.
// Sums COUNT products per frame and holds the result for the consumer.
module prod_accum
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COUNT  = 4,
  parameter int CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  state_e             r_state, w_state_n;
  logic [ACC_W-1:0]   r_acc, w_acc_n;
  logic               r_ovf, w_ovf_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               r_in_ready, w_in_ready_n;
  logic               r_out_valid, w_out_valid_n;
  logic [ACC_W-1:0]   r_sum, w_sum_n;
  logic               r_sum_ovf, w_sum_ovf_n;

  logic               w_in_acc;
  logic               w_out_acc;
  logic [ACC_W:0]     w_add;
  logic               w_ovf_upd;

  assign w_in_acc  = in_valid & r_in_ready;
  assign w_out_acc = r_out_valid & out_ready;

  // One extra bit captures the carry out of the accumulator.
  assign w_add = {1'b0, r_acc}
               + {{(ACC_W - PROD_W + 1){1'b0}}, in_prod};
  assign w_ovf_upd = r_ovf | w_add[ACC_W];

  always_comb begin
    w_state_n   = r_state;
    w_acc_n     = r_acc;
    w_ovf_n     = r_ovf;
    w_cnt_n     = r_cnt;
    w_sum_n     = r_sum;
    w_sum_ovf_n = r_sum_ovf;
    if (clear) begin
      w_state_n = ACCUM;
      w_acc_n   = '0;
      w_ovf_n   = 1'b0;
      w_cnt_n   = '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_in_acc) begin
            w_acc_n = w_add[ACC_W-1:0];
            w_ovf_n = w_ovf_upd;
            w_cnt_n = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(COUNT - 1)) begin
              w_state_n   = HOLD;
              w_sum_n     = w_add[ACC_W-1:0];
              w_sum_ovf_n = w_ovf_upd;
            end
          end
        end
        HOLD: begin
          if (w_out_acc) begin
            w_state_n = ACCUM;
            w_acc_n   = '0;
            w_ovf_n   = 1'b0;
            w_cnt_n   = '0;
          end
        end
        default: w_state_n = ACCUM;
      endcase
    end
    w_in_ready_n  = (w_state_n == ACCUM);
    w_out_valid_n = (w_state_n == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_sum_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_acc       <= w_acc_n;
      r_ovf       <= w_ovf_n;
      r_cnt       <= w_cnt_n;
      r_in_ready  <= w_in_ready_n;
      r_out_valid <= w_out_valid_n;
      r_sum       <= w_sum_n;
      r_sum_ovf   <= w_sum_ovf_n;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_ovf   = r_sum_ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a default 10-bit instance and an
// 8-bit instance share all inputs so wrap behaviour can be checked.
module tb_prod_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [6:0] in_prod;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [9:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0] b_out_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prod_accum u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  prod_accum #(.ACC_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_prod = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 0);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_sum", 32'(a_out_sum), 0);
    chk("rst_out_ovf", 32'(a_out_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(a_in_ready), 1);
    chk("rel_out_valid", 32'(a_out_valid), 0);

    // basic frame 5+10+20+40
    send(5); send(10); send(20);
    chk("f1_pre_valid", 32'(a_out_valid), 0);
    send(40);
    chk("f1_valid", 32'(a_out_valid), 1);
    chk("f1_in_ready", 32'(a_in_ready), 0);
    chk("f1_sum", 32'(a_out_sum), 75);
    chk("f1_ovf", 32'(a_out_ovf), 0);
    take();
    chk("f1_post_ready", 32'(a_in_ready), 1);
    chk("f1_post_valid", 32'(a_out_valid), 0);

    // back-pressure
    send(127); send(127); send(127); send(127);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(a_out_valid), 1);
      chk("bp_in_ready", 32'(a_in_ready), 0);
      chk("bp_sum", 32'(a_out_sum), 508);
      @(negedge clk);
    end
    take();
    chk("bp_post_ready", 32'(a_in_ready), 1);
    chk("bp_post_valid", 32'(a_out_valid), 0);

    // wrap at 8 bits
    send(127); send(127); send(127); send(1);
    chk("ov_b_sum", 32'(b_out_sum), 126);
    chk("ov_b_ovf", 32'(b_out_ovf), 1);
    chk("ov_a_sum", 32'(a_out_sum), 382);
    chk("ov_a_ovf", 32'(a_out_ovf), 0);
    take();
    send(1); send(1); send(1); send(1);
    chk("ov2_b_sum", 32'(b_out_sum), 4);
    chk("ov2_b_ovf", 32'(b_out_ovf), 0);
    take();

    // gapped input
    send(3);
    repeat (3) @(negedge clk);
    chk("gap_valid", 32'(a_out_valid), 0);
    send(3);
    @(negedge clk);
    send(3);
    @(negedge clk);
    chk("gap_valid2", 32'(a_out_valid), 0);
    send(3);
    chk("gap_valid3", 32'(a_out_valid), 1);
    chk("gap_sum", 32'(a_out_sum), 12);
    take();

    // clear mid-frame with a simultaneous accept
    send(50); send(60);
    clear = 1'b1; in_valid = 1'b1; in_prod = 70;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 32'(a_out_valid), 0);
    chk("clr_ready", 32'(a_in_ready), 1);
    send(1); send(2); send(3);
    chk("clr_pre_valid", 32'(a_out_valid), 0);
    send(4);
    chk("clr_sum", 32'(a_out_sum), 10);
    chk("clr_ovf", 32'(a_out_ovf), 0);
    take();

    // clear while holding a result
    send(2); send(2); send(2); send(2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrh_valid", 32'(a_out_valid), 0);
    chk("clrh_ready", 32'(a_in_ready), 1);

    // async reset while holding
    send(9); send(9); send(9); send(9);
    chk("ar_valid_pre", 32'(a_out_valid), 1);
    chk("ar_sum_pre", 32'(a_out_sum), 36);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(a_out_valid), 0);
    chk("ar_sum", 32'(a_out_sum), 0);
    chk("ar_ready", 32'(a_in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rel_ready", 32'(a_in_ready), 1);
    send(7); send(7); send(7); send(7);
    chk("ar_f_valid", 32'(a_out_valid), 1);
    chk("ar_f_sum", 32'(a_out_sum), 28);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
